// File: rtl/mul_sched.sv
// mul_sched: shares one combinational multiplier between two requesters.
// Operands are latched on the request handshake and held for CALC_CYCLES
// settle cycles. The product is then registered and returned with the
// requester id over a valid/ready response handshake.
// Optional feature macro: MUL_SCHED_RR_EN selects round-robin arbitration.
// When the macro is undefined, requester 0 has fixed priority.
module mul_sched #(
    parameter int WIDTH       = 8,
    parameter int CALC_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [2*WIDTH-1:0] rsp_c,
    output logic               busy
);

    localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CALC_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               op_id;
    logic [CW-1:0]      cnt;
    logic               grant;
    logic               req_fire;
    logic               rsp_fire;
    logic [2*WIDTH-1:0] mul_c;

    // The shared multiplier is driven only by the operand registers. Its
    // inputs therefore change only on the request handshake edge, which lets
    // the path be treated as a CALC_CYCLES multicycle path.
    assign mul_c = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);

    // Ready is gated by reset so that neither requester sees an accept
    // while the controller is held in reset.
    assign req0_ready = !rst && (state == IDLE) && !grant && req0_valid;
    assign req1_ready = !rst && (state == IDLE) &&  grant && req1_valid;
    assign req_fire   = req0_ready || req1_ready;
    assign rsp_fire   = rsp_valid && rsp_ready;
    assign busy       = (state != IDLE);

`ifdef MUL_SCHED_RR_EN
    logic last_grant;

    // Remember the winner of each request handshake. It resets to 1 so
    // that requester 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b1;
        else if (req_fire)
            last_grant <= grant;
    end

    // Round-robin: under contention, the requester not granted last time wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else
            grant = req1_valid;
    end
`else
    // Fixed priority: requester 1 wins only when requester 0 is idle.
    always_comb begin
        grant = 1'b0;
        grant = ~req0_valid;
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic: accept -> settle window -> hold response until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_fire)             state_next = CALC;
            CALC:    if (cnt == '0)            state_next = DONE;
            DONE:    if (rsp_fire)             state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, count the settle window, then
    // capture the product and hold it until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= 1'b0;
            cnt       <= '0;
            rsp_c     <= '0;
            rsp_id    <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            if (req_fire) begin
                op_a  <= grant ? req1_a : req0_a;
                op_b  <= grant ? req1_b : req0_b;
                op_id <= grant;
                cnt   <= CNT_LOAD;
            end else if (state == CALC) begin
                if (cnt == '0) begin
                    rsp_c     <= mul_c;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (rsp_fire)
                rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: self-checking bench for mul_sched with WIDTH=8 and
// CALC_CYCLES=2. The expected products come from plain arithmetic. The
// expected requester id comes from the arbitration rule applied to the
// valid pattern.
module tb_mul_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [15:0] rsp_c;

    int passed = 0;
    int total  = 0;
    logic model_last = 1'b1;

`ifdef MUL_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mul_sched #(.WIDTH(8), .CALC_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_c(rsp_c), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One complete operation. Inputs are applied at the falling edge. The
    // response is held back for 'hold' cycles before it is taken.
    task automatic applyStimulus(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                                 input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                                 input int hold);
        logic        exp_id;
        logic [15:0] exp_c;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready  = 1'b1;
        #1;
        if (v0 && v1) exp_id = RR ? ~model_last : 1'b0;
        else          exp_id = v1;
        exp_c = exp_id ? 16'(a1) * 16'(b1) : 16'(a0) * 16'(b0);
        checkOutput("idle_busy",  busy, 0);
        checkOutput("req0_ready", req0_ready, (v0 && !exp_id));
        checkOutput("req1_ready", req1_ready, (v1 &&  exp_id));
        @(posedge clk);
        model_last = exp_id;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom);
            rsp_ready = 1'($urandom);
            #1;
            checkOutput("calc_busy",      busy, 1);
            checkOutput("calc_rsp_valid", rsp_valid, 0);
            checkOutput("calc_ready0",    req0_ready, 0);
            checkOutput("calc_ready1",    req1_ready, 0);
        end
        for (int c = 0; c <= hold; c++) begin
            @(negedge clk);
            rsp_ready = (c == hold);
            req0_a = 8'($urandom); req1_a = 8'($urandom);
            #1;
            checkOutput("rsp_valid",   rsp_valid, 1);
            checkOutput("rsp_c",       rsp_c, exp_c);
            checkOutput("rsp_id",      rsp_id, exp_id);
            checkOutput("done_busy",   busy, 1);
            checkOutput("done_ready0", req0_ready, 0);
            checkOutput("done_ready1", req1_ready, 0);
        end
        @(posedge clk);
        #1;
        checkOutput("after_rsp_valid", rsp_valid, 0);
        checkOutput("after_busy",      busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 8'h0; req0_b = 8'h0; req1_a = 8'h0; req1_b = 8'h0;
        rsp_ready = 1'b0;
        #2;
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_c",     rsp_c, 0);
        checkOutput("reset_rsp_id",    rsp_id, 0);
        checkOutput("reset_busy",      busy, 0);
        checkOutput("reset_ready0",    req0_ready, 0);
        checkOutput("reset_ready1",    req1_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Basic multiply and boundary operands
        applyStimulus(1, 8'h0F, 8'hF0, 0, 8'h00, 8'h00, 0);
        applyStimulus(1, 8'hFF, 8'hFF, 0, 8'h00, 8'h00, 0);
        applyStimulus(0, 8'h00, 8'h00, 1, 8'h00, 8'hAB, 0);
        applyStimulus(1, 8'h01, 8'h80, 0, 8'h00, 8'h00, 0);

        // Contention with both requesters continuously valid
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 8'd3, 8'd5, 1, 8'd7, 8'd9, 0);
        applyStimulus(0, 8'd3, 8'd5, 1, 8'd7, 8'd9, 0);

        // Backpressure: response held for five cycles
        applyStimulus(1, 8'hA5, 8'h3C, 0, 8'h00, 8'h00, 5);
        applyStimulus(0, 8'h00, 8'h00, 1, 8'hC3, 8'h77, 5);

        // Randomized operations with random contention and backpressure
        for (int i = 0; i < 24; i++) begin
            logic v0, v1;
            v0 = 1'($urandom);
            v1 = v0 ? 1'($urandom) : 1'b1;
            applyStimulus(v0, 8'($urandom), 8'($urandom), v1, 8'($urandom), 8'($urandom),
                          int'($urandom_range(0, 3)));
        end

        // Reset during the first CALC cycle discards the operation
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd6; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_busy",      busy, 0);
        checkOutput("midreset_rsp_valid", rsp_valid, 0);
        checkOutput("midreset_ready0",    req0_ready, 0);
        checkOutput("midreset_ready1",    req1_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;
        model_last = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checkOutput("postreset_rsp_valid", rsp_valid, 0);
            checkOutput("postreset_busy",      busy, 0);
        end
        applyStimulus(1, 8'd3, 8'd5, 1, 8'd7, 8'd9, 0);
        applyStimulus(1, 8'd3, 8'd5, 1, 8'd7, 8'd9, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
